amba3_axi_beat_gen: RTL and testbench
=====================================

# amba3_axi_beat_gen

Burst-to-beat expander for the AMBA3/AXI data path. It accepts one burst command per handshake (address, length, size, burst type, ID) and emits one beat descriptor per cycle: beat address, byte-lane window, write-strobe mask and last flag. It sits between the AW/AR channel front end and the W/R data-path logic of the RTL slave and memory models. It replaces ad-hoc per-beat address arithmetic with one registered, back-pressurable generator, parametrised for AXI3 (4-bit len) or longer bursts.

## Interface

- TXID_SIZE, 4, ID width
- ADDR_SIZE, 32, address width
- DATA_SIZE, 128, data bus width in bits; power of two, 8..1024; STRB_SIZE = DATA_SIZE/8, DATA_BASE = log2(STRB_SIZE)
- LEN_SIZE, 4, burst length field width (4 = AXI3, 8 = extended)

Ports:

- aclk  in  1  clock
- areset  in  1  synchronous active-high reset
- cmd_valid  in  1  command valid
- cmd_ready  out  1  command ready
- cmd_id  in  TXID_SIZE  transaction ID
- cmd_addr  in  ADDR_SIZE  start address (may be unaligned)
- cmd_len  in  LEN_SIZE  beats minus one
- cmd_size  in  3  log2 bytes per beat
- cmd_burst  in  2  00 FIXED, 01 INCR, 10 WRAP, 11 reserved
- beat_valid  out  1  beat descriptor valid
- beat_ready  in  1  beat consumed
- beat_id  out  TXID_SIZE  ID of the owning burst
- beat_addr  out  ADDR_SIZE  beat address
- beat_idx  out  LEN_SIZE  beat number, 0..len
- beat_lower  out  DATA_BASE  lowest active byte lane
- beat_upper  out  DATA_BASE  highest active byte lane
- beat_strb  out  STRB_SIZE  lane mask, bits lower..upper set
- beat_last  out  1  final beat of the burst
- beat_err  out  1  burst flagged illegal (see Configuration)

## Operation

- States: IDLE, BUSY. IDLE -> BUSY on cmd handshake. BUSY -> IDLE on last-beat handshake with no new command; BUSY -> BUSY if a command is accepted in the same cycle.
- nbytes = 1 << cmd_size; aligned = addr with low cmd_size bits cleared; total = nbytes*(len+1).
- Beat 0: beat_addr = cmd_addr; lower = cmd_addr[DATA_BASE-1:0]; upper = aligned[DATA_BASE-1:0] + nbytes - 1.
- INCR beat n>0: addr = aligned + n*nbytes; lower = addr[DATA_BASE-1:0]; upper = lower + nbytes - 1.
- WRAP: boundary = floor(addr/total)*total. Beat n>0 addr = aligned + n*nbytes, minus total if the result is >= boundary + total. Lanes are computed as for INCR.
- FIXED: every beat repeats the beat-0 address, lower, upper and strb.
- Address arithmetic is modulo 2^ADDR_SIZE. Lane arithmetic is modulo STRB_SIZE.
- beat_last = (beat_idx == latched len). len = 0 yields a single beat with last = 1.

## Timing

- Reset, held any number of cycles: cmd_ready = 0, beat_valid = 0, and beat_id, beat_addr, beat_idx, beat_lower, beat_upper, beat_strb, beat_last, beat_err all 0.
- Reset asserted mid-burst aborts the burst; no further beats are produced.
- cmd_ready = !areset && (IDLE || (beat_valid && beat_ready && beat_last)). It is combinational from state.
- Latency: a command accepted at edge T produces beat 0 valid after edge T (cycle T+1). Back-to-back bursts run with zero bubbles.
- Throughput: one beat per cycle while beat_ready = 1.
- While beat_valid && !beat_ready, all beat_* outputs hold stable.

## Configuration

- AMBA3_AXI_BEAT_GEN_CHECK_EN defined: a command is flagged illegal if any of the following holds:
  - burst = 11
  - size > DATA_BASE
  - WRAP with len not in {1,3,7,15}
  - WRAP with cmd_addr not aligned to nbytes
  - INCR crossing a 4 KB boundary
- For an illegal burst: beat_err = 1 on every beat, beat_strb = 0, and the beat count and addresses are still generated. Burst 11 is treated as INCR.
- AMBA3_AXI_BEAT_GEN_CHECK_EN undefined: no checks, beat_err tied 0, burst 11 treated as INCR.

## Test plan

- 128-bit bus, INCR size 0 at 0x100, len 4 -> addrs 0x100..0x104, strb 0x0001, 0x0002, 0x0004, 0x0008, 0x0010; last on beat 4 only.
- INCR size 3 at 0x201, len 2 -> strb 0x00fe, 0xff00, 0x00ff; addrs 0x201, 0x208, 0x210.
- WRAP size 2 at 0x704, len 3 -> addrs 0x704, 0x708, 0x70C, 0x700; strb 0x00f0, 0x0f00, 0xf000, 0x000f.
- FIXED size 0 at 0x106, len 4 -> five beats at 0x106, strb 0x0040 each.
- beat_ready low for 3 cycles mid-burst -> outputs stable. A second command presented during the last beat is accepted on the last-beat handshake, and its beat 0 appears in the next cycle. Reset pulsed mid-burst -> beat_valid = 0 the next cycle, and the next command starts at beat_idx 0.
- With CHECK_EN: WRAP len 2, and INCR size 4 at 0xFF0 len 1 -> beat_err = 1 and strb = 0 on all beats. Without CHECK_EN: beat_err = 0, and the address sequences follow the rules above.

Source files
------------

// File: rtl/amba3_axi_beat_gen.sv
// amba3_axi_beat_gen: burst-to-beat expander for the AXI data path.
//
// One burst command is accepted per cmd handshake; the generator then
// emits one registered beat descriptor per cycle (address, byte-lane
// window, strobe mask, last flag), stalling while beat_ready is low.
// The beat 0 descriptor is registered on the command handshake, so beats
// follow one cycle later. A new command is accepted on the last-beat
// handshake, which gives back-to-back bursts with no idle cycle between them.
//
// Parameters:
//   TXID_SIZE  ID width
//   ADDR_SIZE  address width (must exceed 12 for the 4 KB check)
//   DATA_SIZE  data bus width in bits (power of two, 8..1024)
//   LEN_SIZE   burst length field width (4 = AXI3, 8 = extended)
//
// Ports:
//   aclk, areset            clock, synchronous active-high reset
//   cmd_valid / cmd_ready   command handshake
//   cmd_id, cmd_addr        transaction ID, start address (may be unaligned)
//   cmd_len, cmd_size       beats minus one, log2 bytes per beat
//   cmd_burst               00 FIXED, 01 INCR, 10 WRAP, 11 reserved (as INCR)
//   beat_valid / beat_ready beat handshake
//   beat_id, beat_addr      owning ID, beat address
//   beat_idx, beat_last     beat number 0..len, final-beat flag
//   beat_lower, beat_upper  lowest / highest active byte lane
//   beat_strb               lane mask with bits lower..upper set
//   beat_err                burst flagged illegal
//
// Build option: define AMBA3_AXI_BEAT_GEN_CHECK_EN to enable legality
// checks (beat_err set and strobes cleared for illegal bursts). Without it
// beat_err is tied low.

module amba3_axi_beat_gen #(
   parameter int unsigned TXID_SIZE = 4,
   parameter int unsigned ADDR_SIZE = 32,
   parameter int unsigned DATA_SIZE = 128,
   parameter int unsigned LEN_SIZE  = 4,
   localparam int unsigned STRB_SIZE = DATA_SIZE / 8,
   localparam int unsigned DATA_BASE = $clog2(STRB_SIZE)
) (
   input  logic                 aclk,
   input  logic                 areset,
   input  logic                 cmd_valid,
   output logic                 cmd_ready,
   input  logic [TXID_SIZE-1:0] cmd_id,
   input  logic [ADDR_SIZE-1:0] cmd_addr,
   input  logic [LEN_SIZE-1:0]  cmd_len,
   input  logic [2:0]           cmd_size,
   input  logic [1:0]           cmd_burst,
   output logic                 beat_valid,
   input  logic                 beat_ready,
   output logic [TXID_SIZE-1:0] beat_id,
   output logic [ADDR_SIZE-1:0] beat_addr,
   output logic [LEN_SIZE-1:0]  beat_idx,
   output logic [DATA_BASE-1:0] beat_lower,
   output logic [DATA_BASE-1:0] beat_upper,
   output logic [STRB_SIZE-1:0] beat_strb,
   output logic                 beat_last,
   output logic                 beat_err
);

   typedef enum logic [0:0] {StIdle, StBusy} state_e;
   typedef enum logic [1:0] {
      BurstFixed = 2'b00,
      BurstIncr  = 2'b01,
      BurstWrap  = 2'b10
   } burst_e;

   // Byte lanes lo..hi set; hi >= lo holds for every window this block forms.
   function automatic logic [STRB_SIZE-1:0] lane_mask(input logic [DATA_BASE-1:0] lo,
                                                      input logic [DATA_BASE-1:0] hi);
      logic [STRB_SIZE-1:0] m;
      m = '0;
      for (int i = 0; i < STRB_SIZE; i++) begin
         m[i] = (DATA_BASE'(i) >= lo) && (DATA_BASE'(i) <= hi);
      end
      return m;
   endfunction

   state_e               state_q, state_d;
   logic [TXID_SIZE-1:0] id_q, id_d;
   logic [ADDR_SIZE-1:0] addr_q, addr_d;
   logic [LEN_SIZE-1:0]  idx_q, idx_d;
   logic [DATA_BASE-1:0] lower_q, lower_d;
   logic [DATA_BASE-1:0] upper_q, upper_d;
   logic [STRB_SIZE-1:0] strb_q, strb_d;
   logic                 last_q, last_d;
   logic                 err_q, err_d;

   // Latched burst context.
   logic [LEN_SIZE-1:0]  len_q, len_d;
   burst_e               burst_q, burst_d;
   logic [ADDR_SIZE-1:0] nbytes_q, nbytes_d;
   logic [ADDR_SIZE-1:0] total_q, total_d;
   // Size-aligned address of the current beat and its slot in the wrap window.
   logic [ADDR_SIZE-1:0] word_q, word_d;
   logic [LEN_SIZE-1:0]  pos_q, pos_d;

   // Command decode.
   logic [ADDR_SIZE-1:0] c_nbytes, c_aligned, c_len_ext, c_total;
   logic [LEN_SIZE-1:0]  c_pos;
   logic [DATA_BASE-1:0] c_lower, c_upper;
   burst_e               c_burst;
   logic                 c_err;
`ifdef AMBA3_AXI_BEAT_GEN_CHECK_EN
   logic [ADDR_SIZE-1:0] c_last_byte;
`endif

   // Next-beat arithmetic.
   logic [ADDR_SIZE-1:0] n_word;
   logic [LEN_SIZE-1:0]  n_pos;
   logic [DATA_BASE-1:0] n_lower, n_upper;
   logic                 cmd_hs, beat_hs;

   assign beat_valid = (state_q == StBusy);
   assign cmd_ready  = !areset && ((state_q == StIdle) || (beat_valid && beat_ready && last_q));

   always_comb begin
      c_nbytes  = ADDR_SIZE'(1) << cmd_size;
      c_aligned = cmd_addr & ~(c_nbytes - ADDR_SIZE'(1));
      c_len_ext = ADDR_SIZE'(cmd_len) + ADDR_SIZE'(1);
      c_total   = c_len_ext << cmd_size;
      // Slot of the start beat inside the wrap window; the window base is the
      // start address rounded down to a multiple of total.
      c_pos     = LEN_SIZE'((cmd_addr >> cmd_size) % c_len_ext);
      c_lower   = cmd_addr[DATA_BASE-1:0];
      c_upper   = c_aligned[DATA_BASE-1:0] + c_nbytes[DATA_BASE-1:0] - DATA_BASE'(1);
      case (cmd_burst)
         2'b00:   c_burst = BurstFixed;
         2'b10:   c_burst = BurstWrap;
         default: c_burst = BurstIncr;
      endcase
      c_err = 1'b0;
`ifdef AMBA3_AXI_BEAT_GEN_CHECK_EN
      c_last_byte = c_aligned + c_total - ADDR_SIZE'(1);
      c_err = (cmd_burst == 2'b11)
            || (32'(cmd_size) > DATA_BASE)
            || ((c_burst == BurstWrap) && !((cmd_len == LEN_SIZE'(1)) || (cmd_len == LEN_SIZE'(3))
                                           || (cmd_len == LEN_SIZE'(7))
                                           || (cmd_len == LEN_SIZE'(15))))
            || ((c_burst == BurstWrap) && ((cmd_addr & (c_nbytes - ADDR_SIZE'(1))) != '0))
            || ((c_burst == BurstIncr) && (cmd_addr[ADDR_SIZE-1:12] != c_last_byte[ADDR_SIZE-1:12]));
`endif
   end

   always_comb begin
      state_d  = state_q;
      id_d     = id_q;
      addr_d   = addr_q;
      idx_d    = idx_q;
      lower_d  = lower_q;
      upper_d  = upper_q;
      strb_d   = strb_q;
      last_d   = last_q;
      err_d    = err_q;
      len_d    = len_q;
      burst_d  = burst_q;
      nbytes_d = nbytes_q;
      total_d  = total_q;
      word_d   = word_q;
      pos_d    = pos_q;

      n_word = word_q + nbytes_q;
      n_pos  = pos_q + LEN_SIZE'(1);
      if ((burst_q == BurstWrap) && (pos_q == len_q)) begin
         n_word = n_word - total_q;
         n_pos  = '0;
      end
      n_lower = n_word[DATA_BASE-1:0];
      n_upper = n_lower + nbytes_q[DATA_BASE-1:0] - DATA_BASE'(1);

      cmd_hs  = cmd_valid && cmd_ready;
      beat_hs = beat_valid && beat_ready;

      if (cmd_hs) begin
         state_d  = StBusy;
         id_d     = cmd_id;
         addr_d   = cmd_addr;
         idx_d    = '0;
         lower_d  = c_lower;
         upper_d  = c_upper;
         strb_d   = c_err ? '0 : lane_mask(c_lower, c_upper);
         last_d   = (cmd_len == '0);
         err_d    = c_err;
         len_d    = cmd_len;
         burst_d  = c_burst;
         nbytes_d = c_nbytes;
         total_d  = c_total;
         word_d   = c_aligned;
         pos_d    = c_pos;
      end else if (beat_hs) begin
         if (last_q) begin
            state_d = StIdle;
         end else begin
            idx_d  = idx_q + LEN_SIZE'(1);
            last_d = ((idx_q + LEN_SIZE'(1)) == len_q);
            word_d = n_word;
            pos_d  = n_pos;
            // FIXED bursts repeat the beat 0 address and lanes.
            if (burst_q != BurstFixed) begin
               addr_d  = n_word;
               lower_d = n_lower;
               upper_d = n_upper;
               strb_d  = err_q ? '0 : lane_mask(n_lower, n_upper);
            end
         end
      end
   end

   always_ff @(posedge aclk) begin
      if (areset) begin
         state_q  <= StIdle;
         id_q     <= '0;
         addr_q   <= '0;
         idx_q    <= '0;
         lower_q  <= '0;
         upper_q  <= '0;
         strb_q   <= '0;
         last_q   <= 1'b0;
         err_q    <= 1'b0;
         len_q    <= '0;
         burst_q  <= BurstFixed;
         nbytes_q <= '0;
         total_q  <= '0;
         word_q   <= '0;
         pos_q    <= '0;
      end else begin
         state_q  <= state_d;
         id_q     <= id_d;
         addr_q   <= addr_d;
         idx_q    <= idx_d;
         lower_q  <= lower_d;
         upper_q  <= upper_d;
         strb_q   <= strb_d;
         last_q   <= last_d;
         err_q    <= err_d;
         len_q    <= len_d;
         burst_q  <= burst_d;
         nbytes_q <= nbytes_d;
         total_q  <= total_d;
         word_q   <= word_d;
         pos_q    <= pos_d;
      end
   end

   assign beat_id    = id_q;
   assign beat_addr  = addr_q;
   assign beat_idx   = idx_q;
   assign beat_lower = lower_q;
   assign beat_upper = upper_q;
   assign beat_strb  = strb_q;
   assign beat_last  = last_q;
   assign beat_err   = err_q;

endmodule

// File: tb/tb_amba3_axi_beat_gen.sv
// Testbench for amba3_axi_beat_gen (default parameters, 128-bit bus).
// Expected beats are produced from the burst rules by a queue-based model;
// honours AMBA3_AXI_BEAT_GEN_CHECK_EN for the expected error flag.

module tb_amba3_axi_beat_gen;

   logic        aclk = 1'b0;
   logic        areset = 1'b1;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic [3:0]  cmd_id = '0;
   logic [31:0] cmd_addr = '0;
   logic [3:0]  cmd_len = '0;
   logic [2:0]  cmd_size = '0;
   logic [1:0]  cmd_burst = '0;
   logic        beat_valid;
   logic        beat_ready = 1'b0;
   logic [3:0]  beat_id;
   logic [31:0] beat_addr;
   logic [3:0]  beat_idx;
   logic [3:0]  beat_lower;
   logic [3:0]  beat_upper;
   logic [15:0] beat_strb;
   logic        beat_last;
   logic        beat_err;

   always #5 aclk = ~aclk;

   amba3_axi_beat_gen dut (
      .aclk       (aclk),
      .areset     (areset),
      .cmd_valid  (cmd_valid),
      .cmd_ready  (cmd_ready),
      .cmd_id     (cmd_id),
      .cmd_addr   (cmd_addr),
      .cmd_len    (cmd_len),
      .cmd_size   (cmd_size),
      .cmd_burst  (cmd_burst),
      .beat_valid (beat_valid),
      .beat_ready (beat_ready),
      .beat_id    (beat_id),
      .beat_addr  (beat_addr),
      .beat_idx   (beat_idx),
      .beat_lower (beat_lower),
      .beat_upper (beat_upper),
      .beat_strb  (beat_strb),
      .beat_last  (beat_last),
      .beat_err   (beat_err)
   );

   typedef struct {
      logic [3:0]  id;
      logic [31:0] addr;
      logic [3:0]  idx;
      logic [3:0]  lo;
      logic [3:0]  up;
      logic [15:0] strb;
      logic        last;
      logic        err;
   } beat_t;

   beat_t exp_q[$];
   int    checks = 0;
   int    errors = 0;
   logic  last_acc = 1'b0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Expand a burst into its beats directly from the address rules.
   function automatic void push_burst(input logic [3:0] id, input logic [31:0] addr,
                                      input logic [3:0] len, input logic [2:0] size,
                                      input logic [1:0] burst);
      longint unsigned nb, aligned, total, boundary, a;
      int    lo0, up0, lo, up;
      logic  err;
      beat_t b;
      nb       = 64'd1 << size;
      aligned  = (64'(addr) / nb) * nb;
      total    = nb * (64'(len) + 64'd1);
      boundary = (64'(addr) / total) * total;
      err      = 1'b0;
`ifdef AMBA3_AXI_BEAT_GEN_CHECK_EN
      err = (burst == 2'd3) || (size > 3'd4)
         || ((burst == 2'd2) && !(len inside {4'd1, 4'd3, 4'd7, 4'd15}))
         || ((burst == 2'd2) && ((64'(addr) % nb) != 64'd0))
         || (((burst == 2'd1) || (burst == 2'd3))
             && ((64'(addr) >> 12) != ((aligned + total - 64'd1) >> 12)));
`endif
      lo0 = int'(64'(addr) % 64'd16);
      up0 = int'((aligned + nb - 64'd1) % 64'd16);
      for (int n = 0; n <= int'(len); n++) begin
         if ((n == 0) || (burst == 2'd0)) begin
            a  = 64'(addr);
            lo = lo0;
            up = up0;
         end else begin
            a = aligned + 64'(n) * nb;
            if ((burst == 2'd2) && (a >= boundary + total)) a = a - total;
            lo = int'(a % 64'd16);
            up = int'((64'(lo) + nb - 64'd1) % 64'd16);
         end
         b.id   = id;
         b.addr = a[31:0];
         b.idx  = 4'(n);
         b.lo   = 4'(lo);
         b.up   = 4'(up);
         b.strb = '0;
         if (!err) for (int i = lo; i <= up; i++) b.strb[i] = 1'b1;
         b.last = (n == int'(len));
         b.err  = err;
         exp_q.push_back(b);
      end
   endfunction

   // Called at a negedge with inputs set; checks, advances model, waits a cycle.
   task automatic step();
      logic  exp_cr;
      logic  acc;
      beat_t f;
      #1;
      exp_cr = !areset && ((exp_q.size() == 0) || ((exp_q.size() == 1) && beat_ready));
      chk("cmd_ready", cmd_ready, exp_cr);
      chk("beat_valid", beat_valid, exp_q.size() != 0);
      if (exp_q.size() != 0) begin
         f = exp_q[0];
         chk("beat_id", beat_id, f.id);
         chk("beat_addr", beat_addr, f.addr);
         chk("beat_idx", beat_idx, f.idx);
         chk("beat_lower", beat_lower, f.lo);
         chk("beat_upper", beat_upper, f.up);
         chk("beat_strb", beat_strb, f.strb);
         chk("beat_last", beat_last, f.last);
         chk("beat_err", beat_err, f.err);
      end
      acc = cmd_valid && exp_cr;
      if (areset) begin
         exp_q.delete();
      end else begin
         if ((exp_q.size() != 0) && beat_ready) void'(exp_q.pop_front());
         if (acc) push_burst(cmd_id, cmd_addr, cmd_len, cmd_size, cmd_burst);
      end
      last_acc = acc;
      @(negedge aclk);
   endtask

   task automatic reset_chk();
      chk("rst_valid", beat_valid, 1'b0);
      chk("rst_id", beat_id, 4'd0);
      chk("rst_addr", beat_addr, 32'd0);
      chk("rst_idx", beat_idx, 4'd0);
      chk("rst_lower", beat_lower, 4'd0);
      chk("rst_upper", beat_upper, 4'd0);
      chk("rst_strb", beat_strb, 16'd0);
      chk("rst_last", beat_last, 1'b0);
      chk("rst_err", beat_err, 1'b0);
   endtask

   task automatic send_cmd(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                           input logic [2:0] size, input logic [1:0] burst, input bit rnd);
      cmd_id    = id;
      cmd_addr  = addr;
      cmd_len   = len;
      cmd_size  = size;
      cmd_burst = burst;
      cmd_valid = 1'b1;
      for (int k = 0; k < 200; k++) begin
         if (rnd) beat_ready = 1'($urandom_range(0, 1));
         step();
         if (last_acc) break;
      end
      cmd_valid = 1'b0;
      checks++;
      assert (last_acc) else begin
         errors++;
         $error("FAIL cmd_accept observed=timeout expected=handshake");
      end
   endtask

   task automatic drain(input bit rnd);
      for (int k = 0; k < 400; k++) begin
         if (exp_q.size() == 0) break;
         if (rnd) beat_ready = 1'($urandom_range(0, 1));
         step();
      end
      beat_ready = 1'b1;
      checks++;
      assert (exp_q.size() == 0) else begin
         errors++;
         $error("FAIL drain observed=%0d_beats_left expected=0", exp_q.size());
      end
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] ra;
      // Reset held over several edges.
      @(negedge aclk);
      @(negedge aclk);
      reset_chk();
      beat_ready = 1'b1;
      step();
      step();
      reset_chk();
      areset = 1'b0;

      // Directed bursts.
      send_cmd(4'd1, 32'h100, 4'd4, 3'd0, 2'b01, 1'b0);
      drain(1'b0);
      send_cmd(4'd2, 32'h201, 4'd2, 3'd3, 2'b01, 1'b0);
      drain(1'b0);
      send_cmd(4'd3, 32'h704, 4'd3, 3'd2, 2'b10, 1'b0);
      drain(1'b0);
      send_cmd(4'd4, 32'h106, 4'd4, 3'd0, 2'b00, 1'b0);
      drain(1'b0);
      send_cmd(4'd5, 32'h03c, 4'd0, 3'd2, 2'b01, 1'b0);
      drain(1'b0);
      send_cmd(4'd6, 32'hFFFF_FFF8, 4'd3, 3'd2, 2'b01, 1'b0);
      drain(1'b0);

      // Stall mid-burst: outputs must hold.
      send_cmd(4'd7, 32'h1000, 4'd7, 3'd2, 2'b01, 1'b0);
      step();
      step();
      beat_ready = 1'b0;
      step();
      step();
      step();
      beat_ready = 1'b1;
      drain(1'b0);

      // Command presented during the last beat is taken on its handshake.
      send_cmd(4'd8, 32'h2000, 4'd2, 3'd2, 2'b01, 1'b0);
      for (int k = 0; k < 8; k++) begin
         if (exp_q.size() <= 1) break;
         step();
      end
      cmd_id    = 4'd9;
      cmd_addr  = 32'h3004;
      cmd_len   = 4'd1;
      cmd_size  = 3'd2;
      cmd_burst = 2'b10;
      cmd_valid = 1'b1;
      step();
      cmd_valid = 1'b0;
      chk("b2b_accept", last_acc, 1'b1);
      chk("b2b_idx0", beat_idx, 4'd0);
      chk("b2b_id", beat_id, 4'd9);
      drain(1'b0);

      // Reset mid-burst aborts the burst.
      send_cmd(4'd10, 32'h4000, 4'd10, 3'd1, 2'b01, 1'b0);
      step();
      step();
      areset = 1'b1;
      step();
      areset = 1'b0;
      reset_chk();
      step();
      step();
      send_cmd(4'd11, 32'h4002, 4'd3, 3'd1, 2'b01, 1'b0);
      chk("post_rst_idx", beat_idx, 4'd0);
      drain(1'b0);

      // Bursts that are illegal when checking is enabled.
      send_cmd(4'd12, 32'h500, 4'd2, 3'd2, 2'b10, 1'b0);
      drain(1'b0);
      send_cmd(4'd13, 32'hFF0, 4'd1, 3'd4, 2'b01, 1'b0);
      drain(1'b0);
      send_cmd(4'd14, 32'h800, 4'd2, 3'd1, 2'b11, 1'b0);
      drain(1'b0);

      // Randomised bursts, back-pressure, idle gaps and occasional resets.
      for (int t = 0; t < 150; t++) begin
         ra = ($urandom_range(0, 1) == 0) ? $urandom : 32'($urandom_range(0, 32'h1FFF));
         send_cmd(4'($urandom_range(0, 15)), ra, 4'($urandom_range(0, 15)),
                  3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)), 1'b1);
         if ($urandom_range(0, 3) == 0) drain(1'b1);
         if ($urandom_range(0, 29) == 0) begin
            areset = 1'b1;
            step();
            areset = 1'b0;
         end
         if ($urandom_range(0, 4) == 0) begin
            step();
            step();
         end
      end
      drain(1'b1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
